// File: rtl/register_bank_pkg.sv
// Shared constants and dump state type for the architectural register bank.
package register_bank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage : register_bank_pkg

// File: rtl/register_bank_dump_fsm.sv
// Dump sequencer: walks register indices 0..last with a valid/ready handshake
// and tells the top which index to snapshot and when.
//
// state | meaning
// IDLE  | no dump in progress, waiting for dump_start
// SEND  | beat idx_q is presented; advance on valid && ready
// DONE  | last beat accepted, one-cycle done pulse
module register_bank_dump_fsm
    import register_bank_pkg::*;
#(
    parameter int IDX_WIDTH = ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dump_start,
    input  logic                 dump_ready,
    output logic                 dump_valid,
    output logic                 dump_busy,
    output logic                 dump_done,
    output logic [IDX_WIDTH-1:0] dump_addr,
    output logic                 capture_en,
    output logic [IDX_WIDTH-1:0] capture_idx
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

    dump_state_t          state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    // Next-state, index advance and capture strobe.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture_en  = 1'b0;
        capture_idx = idx_q;
        dump_valid  = 1'b0;
        dump_busy   = 1'b0;
        dump_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    capture_en  = 1'b1;
                    capture_idx = '0;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_q + IDX_WIDTH'(1);
                        capture_en  = 1'b1;
                        capture_idx = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign dump_addr = idx_q;

endmodule : register_bank_dump_fsm

// File: rtl/register_bank_core.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one synchronous write port, hardwired x0, and a snapshot dump port.
module register_bank_core
#(
    parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_bank_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_register_1_addr,
    input  logic [ADDR_WIDTH-1:0] read_register_2_addr,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic [ADDR_WIDTH-1:0] write_register_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [DATA_WIDTH-1:0] snap_q, snap_d;
    logic                  capture_en;
    logic [ADDR_WIDTH-1:0] capture_idx;

    // x0 reads as zero; a same-cycle write to the addressed register wins over storage.
    function automatic logic [DATA_WIDTH-1:0] bypass_read(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        if (addr == '0) begin
            return '0;
        end else if (we && (addr == waddr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    assign read_data_1 = bypass_read(read_register_1_addr, regs_q[read_register_1_addr],
                                     write_enable, write_register_addr, write_data);
    assign read_data_2 = bypass_read(read_register_2_addr, regs_q[read_register_2_addr],
                                     write_enable, write_register_addr, write_data);

    // Next storage contents; writes to x0 are dropped so regs_q[0] stays zero.
    always_comb begin
        regs_d = regs_q;
        if (write_enable && (write_register_addr != '0)) begin
            regs_d[write_register_addr] = write_data;
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Snapshot sees the same bypass as the read ports, so a write landing on the
    // captured index in the capture cycle is what gets dumped.
    always_comb begin
        snap_d = snap_q;
        if (capture_en) begin
            snap_d = bypass_read(capture_idx, regs_q[capture_idx],
                                 write_enable, write_register_addr, write_data);
        end
    end

    // Snapshot register; holds a pending beat against later writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign dump_data = snap_q;

    register_bank_dump_fsm #(
        .IDX_WIDTH (ADDR_WIDTH)
    ) u_dump_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .dump_valid  (dump_valid),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done),
        .dump_addr   (dump_addr),
        .capture_en  (capture_en),
        .capture_idx (capture_idx)
    );

endmodule : register_bank_core

// File: tb/tb_register_bank_core.sv
// Self-checking bench for register_bank_core: behavioural model plus directed scenarios.
module tb_register_bank_core;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we;
    logic        dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    register_bank_core dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .read_register_1_addr (ra1),
        .read_register_2_addr (ra2),
        .read_data_1          (rd1),
        .read_data_2          (rd2),
        .write_register_addr  (wa),
        .write_data           (wd),
        .write_enable         (we),
        .dump_start           (dump_start),
        .dump_valid           (dump_valid),
        .dump_ready           (dump_ready),
        .dump_addr            (dump_addr),
        .dump_data            (dump_data),
        .dump_busy            (dump_busy),
        .dump_done            (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_beat: -1 no dump, 0..31 beat number on offer, 32 done cycle.
    logic [31:0] mem [32];
    int          m_beat;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int          nb;
        logic [4:0]  na;
        logic [31:0] nd;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            m_beat <= -1;
            m_addr <= 5'd0;
            m_data <= 32'd0;
        end else begin
            nb = m_beat; na = m_addr; nd = m_data;
            if (m_beat < 0) begin
                if (dump_start) begin nb = 0; na = 5'd0; nd = m_read(5'd0); end
            end else if (m_beat < 32) begin
                if (dump_ready) begin
                    if (m_beat == 31) nb = 32;
                    else begin nb = m_beat + 1; na = 5'(nb); nd = m_read(5'(nb)); end
                end
            end else begin
                nb = -1;
            end
            m_beat <= nb; m_addr <= na; m_data <= nd;
            if (we && wa != 5'd0) mem[wa] <= wd;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd1",        rd1,        m_read(ra1));
            chk("rd2",        rd2,        m_read(ra2));
            chk("dump_valid", {31'd0, dump_valid}, {31'd0, (m_beat >= 0 && m_beat < 32)});
            chk("dump_busy",  {31'd0, dump_busy},  {31'd0, (m_beat >= 0)});
            chk("dump_done",  {31'd0, dump_done},  {31'd0, (m_beat == 32)});
            chk("dump_addr",  {27'd0, dump_addr},  {27'd0, m_addr});
            chk("dump_data",  dump_data,  m_data);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] got [32];
    int beats, ndone, first, done_at;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // mode 0: plain; mode 1: write x3 at its capture, stall on beat 7, restart pulse; mode 2: reset at beat 10
    task automatic run_dump(input int mode);
        int cyc = 0;
        int stall = 0;
        bit fin = 1'b0;
        for (int i = 0; i < 32; i++) got[i] = 32'hFFFF_FFFF;
        beats = 0; ndone = 0; first = -1; done_at = -1;
        we = 1'b0; dump_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (!fin && cyc < 200) begin
            we = 1'b0; dump_ready = 1'b1; dump_start = 1'b0;
            if (mode == 1 && dump_valid) begin
                if (dump_addr == 5'd2) begin
                    we = 1'b1; wa = 5'd3; wd = 32'h3333_0003;
                end else if (dump_addr == 5'd7 && stall < 5) begin
                    dump_ready = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h0000_AAAA; stall++;
                end else if (dump_addr == 5'd12) begin
                    dump_start = 1'b1;
                end
            end
            if (mode == 2 && dump_valid && dump_addr == 5'd10) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", {31'd0, dump_valid}, 32'd0);
                chk("rst_busy",  {31'd0, dump_busy},  32'd0);
                chk("rst_done",  {31'd0, dump_done},  32'd0);
                chk("rst_addr",  {27'd0, dump_addr},  32'd0);
                chk("rst_data",  dump_data, 32'd0);
                ra1 = 5'd10; ra2 = 5'd31;
                #1;
                chk("rst_rd1_x10", rd1, 32'd0);
                chk("rst_rd2_x31", rd2, 32'd0);
                return;
            end
            @(negedge clk);
            if (mode == 1 && !dump_ready) chk("stall_hold_x7", dump_data, 32'h77);
            if (dump_valid && dump_ready) begin
                if (first < 0) first = cyc;
                beats++;
                got[dump_addr] = dump_data;
            end
            if (dump_done) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc >= done_at + 2) fin = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        if (!fin) chk("dump_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // reset state
        ra1 = 5'd0; ra2 = 5'd5;
        @(negedge clk);
        chk("reset_rd1", rd1, 32'd0);
        chk("reset_rd2", rd2, 32'd0);
        chk("reset_valid", {31'd0, dump_valid}, 32'd0);
        chk("reset_busy",  {31'd0, dump_busy},  32'd0);
        chk("reset_done",  {31'd0, dump_done},  32'd0);
        chk("reset_addr",  {27'd0, dump_addr},  32'd0);
        chk("reset_data",  dump_data, 32'd0);
        step();

        // write-first bypass and x0
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
        @(negedge clk);
        chk("bypass_x5", rd1, 32'hDEAD_BEEF);
        step();
        we = 1'b0;
        @(negedge clk);
        chk("stored_x5", rd1, 32'hDEAD_BEEF);
        step();
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ra1 = 5'd0; ra2 = 5'd0;
        @(negedge clk);
        chk("x0_bypass_blocked", rd1, 32'd0);
        step();
        we = 1'b0;
        @(negedge clk);
        chk("x0_stays_zero", rd2, 32'd0);
        step();

        // fill and plain dump
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i * 17);
            step();
        end
        we = 1'b0;
        run_dump(0);
        chk("plain_beats", 32'(beats), 32'd32);
        chk("plain_done_pulses", 32'(ndone), 32'd1);
        chk("plain_valid_to_done", 32'(done_at - first + 1), 32'd33);
        for (int i = 0; i < 32; i++) chk($sformatf("plain_beat%0d", i), got[i], 32'(i * 17));
        chk("plain_beat31_lit", got[31], 32'h20F);

        // stall, capture-cycle write, ignored restart
        run_dump(1);
        chk("mix_beats", 32'(beats), 32'd32);
        chk("mix_done_pulses", 32'(ndone), 32'd1);
        chk("mix_beat3_new", got[3], 32'h3333_0003);
        chk("mix_beat7_old", got[7], 32'h77);
        chk("mix_beat8", got[8], 32'h88);
        ra1 = 5'd7; ra2 = 5'd3;
        @(negedge clk);
        chk("after_x7", rd1, 32'h0000_AAAA);
        chk("after_x3", rd2, 32'h3333_0003);
        step();

        // reset mid-dump
        run_dump(2);
        step();
        step();
        rst_n = 1'b1;
        ra1 = 5'd5; ra2 = 5'd7;
        @(negedge clk);
        chk("post_rst_x5", rd1, 32'd0);
        chk("post_rst_x7", rd2, 32'd0);
        chk("post_rst_busy", {31'd0, dump_busy}, 32'd0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_bank_core

// File: doc/register_bank_core.md
# register_bank_core

Architectural register file of the RISC-V core: the block that consumes the read/write address, data and enable signals driven by the register-bank wiring. It provides two combinational read ports, one synchronous write port with same-cycle write-first bypass and a hardwired-zero x0. It also has a handshaked serial dump port that streams all 32 registers to a testbench or debug sink without stalling the core.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width (NUM_REGS = 2**ADDR_WIDTH)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- read_register_1_addr  in  ADDR_WIDTH  rs1 index
- read_register_2_addr  in  ADDR_WIDTH  rs2 index
- read_data_1  out  DATA_WIDTH  rs1 value
- read_data_2  out  DATA_WIDTH  rs2 value
- write_register_addr  in  ADDR_WIDTH  rd index
- write_data  in  DATA_WIDTH  rd value
- write_enable  in  1  commit write_data to rd at next edge
- dump_start  in  1  request a full register dump; sampled only in IDLE
- dump_valid  out  1  dump beat available
- dump_ready  in  1  sink accepts beat
- dump_addr  out  ADDR_WIDTH  index of current beat
- dump_data  out  DATA_WIDTH  snapshot of register dump_addr
- dump_busy  out  1  dump FSM not IDLE
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops; all reset to 0.
- Write: at rising edge, if write_enable and write_register_addr != 0, regs[write_register_addr] <= write_data. Writes to x0 are discarded.
- Read (combinational): addr 0 returns 0. If write_enable, addr == write_register_addr and addr != 0, returns write_data (write-first bypass). Otherwise returns the stored value. The two ports are independent; both may hit the bypass at once.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0. On dump_start, load index 0, capture its snapshot and go to SEND.
  - SEND: dump_valid=1, dump_busy=1. On dump_valid && dump_ready:
    - index < NUM_REGS-1: increment index and capture the next register's snapshot; stay in SEND.
    - index == NUM_REGS-1: go to DONE.
  - DONE: dump_done=1, dump_valid=0, dump_busy=1 for one cycle, then IDLE.
- Snapshot capture applies the same bypass as the read ports. A write that commits in the capture cycle to the captured index is visible in dump_data.
- dump_addr and dump_data are registered. They are stable while dump_valid && !dump_ready. Later writes to the same register do not alter a pending beat.
- dump_start is ignored in SEND and DONE. Core reads and writes are never blocked by a dump.

## Timing
- Reset values: read ports reflect zeros; dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0; FSM=IDLE.
- Write latency: one edge. The value is visible through the bypass in the same cycle and from storage in the following cycle.
- dump_start sampled high at edge N gives dump_valid=1, dump_addr=0 from N+1.
- With dump_ready held high: one beat per cycle, 32 beats, dump_done high in the cycle after the beat with dump_addr=31. Total 33 cycles from first valid to done.
- dump_ready low holds the beat indefinitely. There is no timeout.
- Reset asserted mid-dump: immediately IDLE with all dump outputs at their reset values. Register contents are cleared.

## Structure
- Shared package register_bank_pkg holds: DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants; the dump_state_t enum {IDLE, SEND, DONE}.
- One sub-module, register_bank_dump_fsm, owns the state, index counter and handshake. It outputs the index to capture and a capture strobe; the top owns storage, bypass and the snapshot register.

## Test plan
- Reset, then read addrs 0/5 -> read_data_1=0, read_data_2=0; dump outputs at reset values.
- Write x5=0xDEADBEEF with read_register_1_addr=5 in the same cycle -> read_data_1=0xDEADBEEF same cycle and after. Write x0=0x1234 -> reads of x0 stay 0.
- Write xi=i*0x11 for i=1..31, pulse dump_start with ready high -> 32 beats addr 0..31, data 0, 0x11 … 0x20F. dump_done pulses once, 33 cycles after first valid.
- During dump, hold dump_ready low on beat addr 7 for 5 cycles while writing x7=0xAAAA -> dump_data for addr 7 stays the old value 0x77 until accepted.
- Pulse dump_start again mid-dump -> ignored; beat count stays 32. Assert rst_n=0 at beat 10 -> dump_valid=0 and dump_busy=0 immediately, all registers read 0.
- Write x3 in the cycle its snapshot is captured (ready high, beat 2 accepted) -> beat addr 3 carries the new value.
